// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit stepping the datapath strobes
// through fetch (T0-T2) and register-format execute (T3-T5), one T-step per
// clock, with a memory-ready timeout, halt opcode and Stop handling.
//
// Ports:
//   Clock, Reset        rising-edge clock, async active-high reset
//   IR[31:0]            instruction register; opcode in IR[31:27]
//   MemReady            memory data valid on Mdatain this cycle
//   Stop                halt request, sampled on an instruction's last step
//   PCout/Zlowout/MDRout          bus drive enables
//   MARin/Zin/PCin/MDRin/IRin/Yin register load enables
//   IncPC, Read         PC increment select, memory read strobe
//   Gra/Grb/Grc, Rin/Rout         register-file field select and enables
//   ALUop[3:0]          ALU function select (execute step only)
//   Run                 high in T0..T5
//   Illegal             one-cycle pulse in T3 on an undefined opcode
//   BusErr              sticky memory-timeout flag, cleared by Reset
//   Step[2:0]           current T-step, 7 in RESET_ST/HALT

module control_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MemReady,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  ALUop,
    output logic        Run,
    output logic        Illegal,
    output logic        BusErr,
    output logic [2:0]  Step
);

    localparam logic [2:0] T0       = 3'd0;
    localparam logic [2:0] T1       = 3'd1;
    localparam logic [2:0] T2       = 3'd2;
    localparam logic [2:0] T3       = 3'd3;
    localparam logic [2:0] T4       = 3'd4;
    localparam logic [2:0] T5       = 3'd5;
    localparam logic [2:0] RESET_ST = 3'd6;
    localparam logic [2:0] HALT     = 3'd7;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       bus_err_q, bus_err_d;

    logic [4:0] opcode;
    logic       is_bin;
    logic       is_un;
    logic       is_nop;
    logic       is_halt;
    logic [3:0] alu_sel;

    // Only the opcode field is decoded here; the register fields are
    // consumed by the datapath through Gra/Grb/Grc.
    logic unused_ir;
    assign unused_ir = ^IR[26:0];

    assign opcode = IR[31:27];
    assign BusErr = bus_err_q;

    // Opcode classification.
    always_comb begin
        is_bin  = 1'b0;
        is_un   = 1'b0;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        alu_sel = 4'b0000;
        case (opcode)
            5'b00011: begin is_bin = 1'b1; alu_sel = 4'b0000; end
            5'b00100: begin is_bin = 1'b1; alu_sel = 4'b0001; end
            5'b00101: begin is_bin = 1'b1; alu_sel = 4'b0010; end
            5'b00110: begin is_bin = 1'b1; alu_sel = 4'b0011; end
            5'b00111: begin is_bin = 1'b1; alu_sel = 4'b0100; end
            5'b01000: begin is_bin = 1'b1; alu_sel = 4'b0101; end
            5'b10000: begin is_un  = 1'b1; alu_sel = 4'b0110; end
            5'b10001: begin is_un  = 1'b1; alu_sel = 4'b0111; end
            5'b11010: is_nop  = 1'b1;
            5'b11011: is_halt = 1'b1;
            default:  ;
        endcase
    end

    // Next-state, timeout counter and sticky bus error.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        case (state_q)
            RESET_ST: state_d = T0;
            T0: begin
                state_d = T1;
                cnt_d   = 8'd0;
            end
            T1: begin
                if (MemReady) begin
                    state_d = T2;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            T2: state_d = T3;
            T3: begin
                if (is_bin || is_un) begin
                    state_d = T4;
                end else if (is_halt) begin
                    state_d = HALT;
                end else begin
                    // nop and illegal opcodes end here
                    state_d = Stop ? HALT : T0;
                end
            end
            T4: begin
                if (is_bin) begin
                    state_d = T5;
                end else begin
                    state_d = Stop ? HALT : T0;
                end
            end
            T5:      state_d = Stop ? HALT : T0;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= RESET_ST;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Moore strobe decode from state and IR.
    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        Zin     = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        ALUop   = 4'b0000;
        Run     = 1'b0;
        Illegal = 1'b0;
        Step    = 3'd7;
        case (state_q)
            T0: begin
                Run   = 1'b1;
                Step  = 3'd0;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                // PCin repeats while waiting; Z is not reloaded so PC holds.
                Run     = 1'b1;
                Step    = 3'd1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                Run    = 1'b1;
                Step   = 3'd2;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Run  = 1'b1;
                Step = 3'd3;
                if (is_bin) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_un) begin
                    Grb   = 1'b1;
                    Rout  = 1'b1;
                    Zin   = 1'b1;
                    ALUop = alu_sel;
                end else if (!is_nop && !is_halt) begin
                    Illegal = 1'b1;
                end
            end
            T4: begin
                Run  = 1'b1;
                Step = 3'd4;
                if (is_bin) begin
                    Grc   = 1'b1;
                    Rout  = 1'b1;
                    Zin   = 1'b1;
                    ALUop = alu_sel;
                end else if (is_un) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            T5: begin
                Run  = 1'b1;
                Step = 3'd5;
                if (is_bin) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer: expected strobes are
// generated per instruction from the T-step rules, cycle by cycle.

module tb_control_sequencer;

    localparam int TO = 16;

    localparam logic [15:0] M_PCOUT = 16'h8000;
    localparam logic [15:0] M_ZLOW  = 16'h4000;
    localparam logic [15:0] M_MDROUT = 16'h2000;
    localparam logic [15:0] M_MARIN = 16'h1000;
    localparam logic [15:0] M_ZIN   = 16'h0800;
    localparam logic [15:0] M_PCIN  = 16'h0400;
    localparam logic [15:0] M_MDRIN = 16'h0200;
    localparam logic [15:0] M_IRIN  = 16'h0100;
    localparam logic [15:0] M_YIN   = 16'h0080;
    localparam logic [15:0] M_INCPC = 16'h0040;
    localparam logic [15:0] M_READ  = 16'h0020;
    localparam logic [15:0] M_GRA   = 16'h0010;
    localparam logic [15:0] M_GRB   = 16'h0008;
    localparam logic [15:0] M_GRC   = 16'h0004;
    localparam logic [15:0] M_RIN   = 16'h0002;
    localparam logic [15:0] M_ROUT  = 16'h0001;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        MemReady = 1'b0;
    logic        Stop = 1'b0;
    logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin;
    logic        Yin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [3:0]  ALUop;
    logic        Run, Illegal, BusErr;
    logic [2:0]  Step;

    int checks = 0;
    int fails  = 0;
    int ncyc   = 0;
    logic buserr_m = 1'b0;
    logic halted_m = 1'b0;
    logic aborted  = 1'b0;

    control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR),
        .MemReady(MemReady), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .ALUop(ALUop), .Run(Run), .Illegal(Illegal),
        .BusErr(BusErr), .Step(Step)
    );

    always #5 Clock = ~Clock;

    logic [25:0] obs;
    assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                  Yin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                  ALUop, Run, Illegal, BusErr, Step};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] ev(input logic [15:0] s,
                                       input logic [3:0] a,
                                       input logic run, input logic ill,
                                       input logic [2:0] st);
        return {s, a, run, ill, buserr_m, st};
    endfunction

    // 0 binary, 1 unary, 2 nop, 3 halt, 4 illegal
    function automatic int cls(input logic [4:0] op, output logic [3:0] a);
        a = 4'd0;
        case (op)
            5'd3:  begin a = 4'd0; return 0; end
            5'd4:  begin a = 4'd1; return 0; end
            5'd5:  begin a = 4'd2; return 0; end
            5'd6:  begin a = 4'd3; return 0; end
            5'd7:  begin a = 4'd4; return 0; end
            5'd8:  begin a = 4'd5; return 0; end
            5'd16: begin a = 4'd6; return 1; end
            5'd17: begin a = 4'd7; return 1; end
            5'd26: return 2;
            5'd27: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic step(input logic [25:0] e, input logic mr,
                        input logic stp, input logic [31:0] ir);
        @(negedge Clock);
        MemReady = mr;
        Stop = stp;
        IR = ir;
        #1;
        check($sformatf("step%0d", e[2:0]), {6'd0, obs}, {6'd0, e});
        ncyc++;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic ab(input int abort);
        return (abort != 0) && (ncyc >= abort);
    endfunction

    // One instruction: T0, T1 with `waits` not-ready cycles, T2, execute.
    task automatic run_instr(input logic [31:0] ir, input int waits,
                             input logic stp, input int abort);
        logic [3:0] a;
        int c;
        ncyc = 0;
        aborted = 1'b0;
        step(ev(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 1, 0, 0),
             rb(), rb(), $urandom);
        if (ab(abort)) begin aborted = 1'b1; return; end
        for (int i = 0; i < TO; i++) begin
            if (i == waits) begin
                step(ev(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 0, 1, 0, 1),
                     1'b1, rb(), $urandom);
                break;
            end
            step(ev(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 0, 1, 0, 1),
                 1'b0, rb(), $urandom);
            if (i == TO - 1) begin
                buserr_m = 1'b1;
                halted_m = 1'b1;
                return;
            end
            if (ab(abort)) begin aborted = 1'b1; return; end
        end
        if (ab(abort)) begin aborted = 1'b1; return; end
        step(ev(M_MDROUT | M_IRIN, 0, 1, 0, 2), rb(), rb(), ir);
        if (ab(abort)) begin aborted = 1'b1; return; end
        c = cls(ir[31:27], a);
        case (c)
            0: begin
                step(ev(M_GRB | M_ROUT | M_YIN, 0, 1, 0, 3), rb(), rb(), ir);
                if (ab(abort)) begin aborted = 1'b1; return; end
                step(ev(M_GRC | M_ROUT | M_ZIN, a, 1, 0, 4), rb(), rb(), ir);
                if (ab(abort)) begin aborted = 1'b1; return; end
                step(ev(M_ZLOW | M_GRA | M_RIN, 0, 1, 0, 5), rb(), stp, ir);
            end
            1: begin
                step(ev(M_GRB | M_ROUT | M_ZIN, a, 1, 0, 3), rb(), rb(), ir);
                if (ab(abort)) begin aborted = 1'b1; return; end
                step(ev(M_ZLOW | M_GRA | M_RIN, 0, 1, 0, 4), rb(), stp, ir);
            end
            2: step(ev(0, 0, 1, 0, 3), rb(), stp, ir);
            3: step(ev(0, 0, 1, 0, 3), rb(), rb(), ir);
            default: step(ev(0, 0, 1, 1, 3), rb(), stp, ir);
        endcase
        if (c == 3 || stp) halted_m = 1'b1;
        if (ab(abort)) aborted = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(ev(0, 0, 0, 0, 7), 1'b1, rb(), $urandom);
    endtask

    // Called right after a step check, i.e. mid-cycle.
    task automatic do_reset();
        #1;
        Reset = 1'b1;
        buserr_m = 1'b0;
        halted_m = 1'b0;
        #1;
        check("rst_async", {6'd0, obs}, {6'd0, ev(0, 0, 0, 0, 7)});
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("rst_rel", {6'd0, obs}, {6'd0, ev(0, 0, 0, 0, 7)});
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] ops [10];
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                5'd16, 5'd17, 5'd26, 5'd27};
        if ($urandom_range(0, 9) < 8)
            return {ops[$urandom_range(0, 9)], 27'($urandom)};
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ab_n;
        logic s;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("rst_hold", {6'd0, obs}, {6'd0, ev(0, 0, 0, 0, 7)});
        Reset = 1'b0;
        #1;
        check("rst_rel", {6'd0, obs}, {6'd0, ev(0, 0, 0, 0, 7)});

        run_instr(32'h28918000, 0, 1'b0, 0);
        run_instr(32'h28918000, 3, 1'b0, 0);
        run_instr(32'h88900000, 0, 1'b0, 0);
        run_instr({5'b11111, 27'd0}, 0, 1'b0, 0);
        run_instr(32'h20000000, 15, 1'b0, 0);
        run_instr(32'h18000000, 0, 1'b1, 0);
        halt_cycles(3);
        do_reset();
        run_instr({5'b11011, 27'd0}, 1, 1'b0, 0);
        halt_cycles(3);
        do_reset();
        run_instr(32'h28918000, 40, 1'b0, 0);
        halt_cycles(4);
        do_reset();
        run_instr(32'h28918000, 0, 1'b0, 5);
        do_reset();

        for (int n = 0; n < 120; n++) begin
            w = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4)
                                           : $urandom_range(14, 20);
            s = ($urandom_range(0, 9) == 0);
            ab_n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
            run_instr(rand_ir(), w, s, ab_n);
            if (aborted) begin
                do_reset();
            end else if (halted_m) begin
                halt_cycles(2);
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit that drives the datapath's strobe inputs (register-out, register-in, ALU op, memory read) one T-step per clock.
Runs instruction fetch (T0–T2), decodes IR[31:27], and sequences register-format ALU instructions (T3–T5).
Sits directly upstream of the datapath and replaces bench-driven control signals.
Includes a memory-ready wait with timeout, halt and stop handling.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive T1 cycles waiting for MemReady before bus-error halt (legal range 2..255).

Ports:
Clock  in  1  system clock; all state changes on rising edge
Reset  in  1  asynchronous, active-high reset
IR  in  32  instruction register contents from datapath; opcode IR[31:27]
MemReady  in  1  memory has data on Mdatain this cycle
Stop  in  1  halt request, sampled at instruction end
PCout, Zlowout, MDRout  out  1 each  bus drive enables
MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  register load enables
IncPC, Read  out  1 each  PC increment select; memory read strobe
Gra, Grb, Grc  out  1 each  select IR field Ra/Rb/Rc for register-file access
Rin, Rout  out  1 each  register-file write / bus-drive enable for selected field
ALUop  out  4  ALU function select
Run  out  1  high while executing
Illegal  out  1  one-cycle pulse on undefined opcode
BusErr  out  1  sticky memory-timeout flag
Step  out  3  current T-step 0..5; 7 in RESET_ST/HALT

Behaviour:
- States: RESET_ST, T0, T1, T2, T3, T4, T5, HALT.
- Outputs are Moore-decoded from state and IR. They are valid for the whole cycle and are consumed by the datapath at the next rising edge.
- Any signal not listed for a step is 0. ALUop is 0000 outside the execute step.
- Reset: state goes to RESET_ST immediately (async). All outputs 0, BusErr=0, Step=7, timeout counter 0.
- RESET_ST goes to T0 unconditionally at the first edge after Reset deasserts.
- Run=1 in T0–T5, 0 in RESET_ST and HALT.
- T0: PCout, MARin, IncPC, Zin. Next state T1; timeout counter cleared.
- T1: Zlowout, PCin, Read, MDRin, held every cycle in T1 (repeated PCin is harmless because Z is not reloaded).
  - MemReady=1: next state T2.
  - Otherwise the counter increments. On the cycle where counter = MEM_TIMEOUT-1 and MemReady=0: next state HALT, BusErr set.
- T2: MDRout, IRin. Next state T3; IR is valid from T3 onward.
- T3 decode (opcode to ALUop):
  - 00011 add → 0000; 00100 sub → 0001; 00101 and → 0010; 00110 or → 0011; 00111 shl → 0100; 01000 shr → 0101 (binary class).
  - 10000 neg → 0110; 10001 not → 0111 (unary class).
  - 11010 nop; 11011 halt; all others illegal.
- Binary instructions:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALUop.
  - T5: Zlowout, Gra, Rin.
- Unary instructions:
  - T3: Grb, Rout, Zin, ALUop.
  - T4: Zlowout, Gra, Rin.
  - T5 is skipped.
- nop: T3 asserts nothing; next state T0.
- halt opcode: T3 asserts nothing; next state HALT.
- Illegal opcode: Illegal=1 during T3 only; next state T0 (instruction skipped).
- Stop is sampled only on the final step of an instruction (T5 binary, T4 unary, T3 nop/illegal). If Stop=1 there, next state is HALT instead of T0.
- HALT is absorbing; only Reset exits. All strobes are 0 in HALT.
- BusErr clears only on Reset.
- Reset mid-instruction: strobes drop in the same timestep, with no completion of the current step.
- Step reports the T-number of the current state.

Test Plan:
- Reset 2 cycles, MemReady=1, IR=0x28918000 (and R1,R2,R3) → Step 0,1,2,3,4,5,0.
  - T3 Grb/Rout/Yin; T4 Grc/Rout/Zin, ALUop=0010; T5 Zlowout/Gra/Rin.
  - Run=1 throughout; T0 recurs 6 cycles after the first T0.
- MemReady low for the first 3 T1 cycles, high on the 4th → T1 lasts 4 cycles with Read/MDRin held high. IRin stays 0 until T2; BusErr=0.
- MemReady held 0 → exactly 16 cycles in T1, then HALT: BusErr=1, Run=0, Step=7, all strobes 0. A later MemReady=1 has no effect.
- IR=0x88900000 (not R1,R2) → T3 Grb/Rout/Zin, ALUop=0111; T4 Zlowout/Gra/Rin; next Step=0 (no T5).
- IR opcode 11111 → Illegal=1 for the single T3 cycle, then T0. IR opcode 11011 → HALT, Run=0 until Reset.
- Stop=1 during T5 of the add instruction → HALT follows. Separately, Reset asserted mid-T4 → all outputs 0 before the next edge; first T0 follows one cycle after release.
